fetch_stage: RTL and testbench

- Front stage of the two-stage pipeline; owns the PC.
- Issues word reads to the instruction-memory port.
- Registers the fetched word, its PC and PC+4 into the fetch/execute latch. The latched instruction word is what the control unit decodes in execute.
- Absorbs instruction-memory wait states, execute stalls and branch/jump redirects. No instruction is ever lost or duplicated.

---
 rtl/rv32i_types_pkg.sv | 28 ++
 rtl/fetch_hold_buffer.sv | 32 +++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I front-end types: machine word, fetch FSM states and the
// fetch/execute latch layout.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    // addi x0,x0,0 - what execute sees when the latch holds a bubble
    localparam word_t NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t pc4;
        logic  valid;
    } fd_latch_t;

    localparam fd_latch_t FD_RESET = '{instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Single-entry parking slot for a fetched word that execute could not take.
// Load/drain/flush act on the next edge; flush and drain take priority over load.
module fetch_hold_buffer
    import rv32i_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  drain,
    input  logic  flush,
    input  word_t load_instr,
    input  word_t load_pc,
    output logic  hold_vld,
    output word_t hold_instr,
    output word_t hold_pc
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_vld   <= 1'b0;
            hold_instr <= NOP_INSTR;
            hold_pc    <= '0;
        end else if (flush || drain) begin
            hold_vld   <= 1'b0;
        end else if (load) begin
            hold_vld   <= 1'b1;
            hold_instr <= load_instr;
            hold_pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC owner and instruction fetch: one word/cycle on zero-wait memory into the fd latch.
// Bus address frozen while busy; execute stall parks a completed word and drops the request.
module fetch_stage
    import rv32i_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0200
) (
    input  logic  CLK,
    input  logic  nRST,
    output logic  imem_ren,
    output word_t imem_addr,
    input  word_t imem_rdata,
    input  logic  imem_busy,
    input  logic  ex_stall,
    input  logic  redirect,
    input  word_t redirect_addr,
    output word_t fd_instr,
    output word_t fd_pc,
    output word_t fd_pc4,
    output logic  fd_valid,
    output logic  fetch_misaligned
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        pend_pc_q, pend_pc_d;
    logic         kill_q, kill_d;
    logic         mis_q, mis_d;
    fd_latch_t    fd_q, fd_d;

    logic  hold_load, hold_drain, hold_flush;
    logic  hold_vld;
    word_t hold_instr, hold_pc;
    word_t target, pc_plus4;

    assign target   = align_word(redirect_addr);
    assign pc_plus4 = pc_q + 32'd4;

    fetch_hold_buffer u_hold (
        .CLK        (CLK),
        .nRST       (nRST),
        .load       (hold_load),
        .drain      (hold_drain),
        .flush      (hold_flush),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .hold_vld   (hold_vld),
        .hold_instr (hold_instr),
        .hold_pc    (hold_pc)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pend_pc_q <= RESET_PC;
            kill_q    <= 1'b0;
            mis_q     <= 1'b0;
            fd_q      <= FD_RESET;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            kill_q    <= kill_d;
            mis_q     <= mis_d;
            fd_q      <= fd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        kill_d     = kill_q;
        mis_d      = mis_q;
        fd_d       = fd_q;
        hold_load  = 1'b0;
        hold_drain = 1'b0;
        hold_flush = 1'b0;

        if (redirect) begin
            mis_d = |redirect_addr[1:0];
        end

        case (state_q)
            FETCH: begin
                if (imem_busy) begin
                    // Address must stay put until the bus completes; remember the target instead.
                    if (redirect) begin
                        pend_pc_d   = target;
                        kill_d      = 1'b1;
                        fd_d.valid  = 1'b0;
                        fd_d.instr  = NOP_INSTR;
                    end else if (!ex_stall) begin
                        fd_d.valid  = 1'b0;
                        fd_d.instr  = NOP_INSTR;
                    end
                end else if (redirect) begin
                    pc_d        = target;
                    kill_d      = 1'b0;
                    fd_d.valid  = 1'b0;
                    fd_d.instr  = NOP_INSTR;
                end else if (kill_q) begin
                    pc_d   = pend_pc_q;
                    kill_d = 1'b0;
                    if (!ex_stall) begin
                        fd_d.valid = 1'b0;
                        fd_d.instr = NOP_INSTR;
                    end
                end else if (!ex_stall) begin
                    fd_d = '{instr: imem_rdata, pc: pc_q, pc4: pc_plus4, valid: 1'b1};
                    pc_d = pc_plus4;
                end else begin
                    hold_load = 1'b1;
                    pc_d      = pc_plus4;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    hold_flush = 1'b1;
                    pc_d       = target;
                    fd_d.valid = 1'b0;
                    fd_d.instr = NOP_INSTR;
                    state_d    = FETCH;
                end else if (!ex_stall) begin
                    fd_d       = '{instr: hold_instr, pc: hold_pc, pc4: hold_pc + 32'd4, valid: hold_vld};
                    hold_drain = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_ren         = nRST && (state_q == FETCH);
    assign imem_addr        = pc_q;
    assign fd_instr         = fd_q.instr;
    assign fd_pc            = fd_q.pc;
    assign fd_pc4           = fd_q.pc4;
    assign fd_valid         = fd_q.valid;
    assign fetch_misaligned = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected fd transfers into a
// queue, a negedge monitor pops them whenever execute accepts a valid fd word.
module tb_fetch_stage;
    import rv32i_types_pkg::*;

    typedef struct {
        word_t instr;
        word_t pc;
        word_t pc4;
    } exp_t;

    logic  CLK;
    logic  nRST;
    logic  imem_ren;
    word_t imem_addr;
    word_t imem_rdata;
    logic  imem_busy;
    logic  ex_stall;
    logic  redirect;
    word_t redirect_addr;
    word_t fd_instr, fd_pc, fd_pc4;
    logic  fd_valid;
    logic  fetch_misaligned;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    fetch_stage #(.RESET_PC(32'h0000_0200)) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .imem_ren         (imem_ren),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_busy        (imem_busy),
        .ex_stall         (ex_stall),
        .redirect         (redirect),
        .redirect_addr    (redirect_addr),
        .fd_instr         (fd_instr),
        .fd_pc            (fd_pc),
        .fd_pc4           (fd_pc4),
        .fd_valid         (fd_valid),
        .fetch_misaligned (fetch_misaligned)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic word_t mem_word(input word_t a);
        case (a)
            32'h0000_0200: return 32'h0000_0093;
            32'h0000_0204: return 32'h0010_0113;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string nm, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input word_t a);
        exp_t e;
        e.instr = mem_word(a);
        e.pc    = a;
        e.pc4   = a + 32'd4;
        exp_q.push_back(e);
    endtask

    // One clock: drive inputs, check bus (and optionally a bubble) at negedge.
    task automatic step(input logic b, input logic s, input logic r, input word_t ra,
                        input logic e_ren, input word_t e_addr, input logic e_bub, input string nm);
        imem_busy     = b;
        ex_stall      = s;
        redirect      = r;
        redirect_addr = ra;
        @(negedge CLK);
        check({nm, " ren"}, {31'd0, imem_ren}, {31'd0, e_ren});
        if (e_ren) check({nm, " addr"}, imem_addr, e_addr);
        if (e_bub) begin
            check({nm, " bubble valid"}, {31'd0, fd_valid}, 32'd0);
            check({nm, " bubble instr"}, fd_instr, NOP_INSTR);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " ren"}, {31'd0, imem_ren}, 32'd0);
        check({nm, " fd_instr"}, fd_instr, NOP_INSTR);
        check({nm, " fd_pc"}, fd_pc, 32'd0);
        check({nm, " fd_pc4"}, fd_pc4, 32'd0);
        check({nm, " fd_valid"}, {31'd0, fd_valid}, 32'd0);
        check({nm, " misaligned"}, {31'd0, fetch_misaligned}, 32'd0);
    endtask

    // Execute accepts the fd word on any edge where it is valid and not stalled.
    always @(negedge CLK) begin
        if (nRST && fd_valid && !ex_stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected fd transfer pc", fd_pc, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fd_instr", fd_instr, e.instr);
                check("fd_pc", fd_pc, e.pc);
                check("fd_pc4", fd_pc4, e.pc4);
            end
        end
    end

    initial begin
        nRST          = 1'b0;
        imem_busy     = 1'b0;
        ex_stall      = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        nRST = 1'b1;

        // zero-wait streaming
        push(32'h200); step(0, 0, 0, 0, 1, 32'h200, 0, "s1");
        push(32'h204); step(0, 0, 0, 0, 1, 32'h204, 0, "s2");
        push(32'h208); step(0, 0, 0, 0, 1, 32'h208, 0, "s3");
        // three wait states
        step(1, 0, 0, 0, 1, 32'h20C, 0, "w1");
        step(1, 0, 0, 0, 1, 32'h20C, 1, "w2");
        step(1, 0, 0, 0, 1, 32'h20C, 1, "w3");
        push(32'h20C); step(0, 0, 0, 0, 1, 32'h20C, 1, "w4");
        // execute stall as 0x210 completes
        push(32'h210); step(0, 1, 0, 0, 1, 32'h210, 0, "st1");
        step(0, 1, 0, 0, 0, 0, 0, "st2");
        check("stall hold fd_pc", fd_pc, 32'h20C);
        check("stall hold fd_valid", {31'd0, fd_valid}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, "st3");
        push(32'h214); step(0, 0, 0, 0, 1, 32'h214, 0, "st4");
        // redirect during a wait state
        step(1, 0, 0, 0, 1, 32'h218, 0, "rb1");
        step(1, 0, 1, 32'h400, 1, 32'h218, 1, "rb2");
        step(0, 0, 0, 0, 1, 32'h218, 1, "rb3");
        push(32'h400); step(0, 0, 0, 0, 1, 32'h400, 1, "rb4");
        push(32'h404); step(0, 0, 0, 0, 1, 32'h404, 0, "rb5");
        // misaligned target, then cleared by an aligned one
        step(0, 0, 1, 32'h402, 1, 32'h408, 0, "ma1");
        check("misaligned set", {31'd0, fetch_misaligned}, 32'd1);
        push(32'h400); step(0, 0, 0, 0, 1, 32'h400, 1, "ma2");
        step(0, 0, 1, 32'h500, 1, 32'h404, 0, "ma3");
        check("misaligned cleared", {31'd0, fetch_misaligned}, 32'd0);
        push(32'h500); step(0, 0, 0, 0, 1, 32'h500, 1, "ma4");
        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h504, 0, "wr1");
        push(32'hFFFF_FFFC); step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, "wr2");
        check("wrap fd_pc4", fd_pc4, 32'd0);
        push(32'h0); step(0, 0, 0, 0, 1, 32'h0, 0, "wr3");
        // reset in the middle of a wait state
        step(1, 0, 0, 0, 1, 32'h4, 0, "rs1");
        nRST = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        @(posedge CLK);
        #1;
        imem_busy = 1'b0;
        #1;
        check_reset_outputs("reset completion ignored");
        nRST = 1'b1;
        push(32'h200); step(0, 0, 0, 0, 1, 32'h200, 0, "rs2");
        step(0, 0, 0, 0, 1, 32'h204, 0, "rs3");
        // stall parks 0x208, then a redirect flushes both latch and buffer
        step(0, 1, 0, 0, 1, 32'h208, 0, "hr1");
        check("hold fd_pc", fd_pc, 32'h204);
        check("hold ren", {31'd0, imem_ren}, 32'd0);
        step(0, 1, 1, 32'h300, 0, 0, 0, "hr2");
        check("hold redirect flush", {31'd0, fd_valid}, 32'd0);
        push(32'h300); step(0, 0, 0, 0, 1, 32'h300, 1, "hr3");
        step(1, 0, 0, 0, 1, 32'h304, 0, "hr4");
        step(1, 0, 0, 0, 1, 32'h304, 1, "hr5");

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
